// File: rtl/timer_irq_ctrl_if.sv
// timer_irq_ctrl_if -- signal bundle between the timer interrupt controller,
// the timer sources it serves and the CPU that acknowledges interrupts.
//
// Handshake: irq is the request valid, irq_id its payload, and cpu_ack the
// ready. A transfer happens on a rising edge where irq and cpu_ack are both
// high. irq_id holds steady while irq is high, and irq stays high until that
// transfer. cpu_ack is ignored whenever irq is low. src_ack is a one-cycle,
// one-hot pulse that follows each transfer and is returned to the serviced
// timer.
interface timer_irq_ctrl_if #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
);
    logic [N_SRC-1:0] src_done;
    logic [N_SRC-1:0] src_ack;
    logic             mask_we;
    logic [N_SRC-1:0] mask_wdata;
    logic [N_SRC-1:0] mask;
    logic             irq;
    logic [ID_W-1:0]  irq_id;
    logic             cpu_ack;

    // The controller side.
    modport slave (
        input  src_done,
        input  mask_we,
        input  mask_wdata,
        input  cpu_ack,
        output src_ack,
        output mask,
        output irq,
        output irq_id
    );

    // The environment side: timers plus the CPU.
    modport master (
        output src_done,
        output mask_we,
        output mask_wdata,
        output cpu_ack,
        input  src_ack,
        input  mask,
        input  irq,
        input  irq_id
    );
endinterface

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl -- collects the sticky done levels of up to N_SRC timers and
// presents one masked, prioritised interrupt request with a source ID to the
// CPU. A CPU acknowledge returns a one-cycle src_ack pulse to the serviced
// timer.
//
// Optional feature macro: TIMER_IRQ_RR_EN
//   defined   : round-robin arbitration. The search starts one past the last
//               granted source and wraps around.
//   undefined : fixed priority, where the lowest index wins. No pointer
//               register exists in this build.
//
// The FSM state is exposed on state_dbg: 0 = IDLE, 1 = ASSERT, 2 = ACK.
module timer_irq_ctrl #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    timer_irq_ctrl_if.slave      bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t           state;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] pending;
    logic [ID_W-1:0]  sel_id;
    logic [N_SRC-1:0] ack_onehot;
    logic             irq_q;
    logic [ID_W-1:0]  irq_id_q;
    logic [N_SRC-1:0] src_ack_q;

    // Only enabled sources can raise a request. A new mask value is seen here
    // from the cycle after its write edge.
    assign pending = bus.src_done & mask_q;

`ifdef TIMER_IRQ_RR_EN
    // Index where the next search starts (last granted + 1, mod N_SRC).
    logic [ID_W-1:0]    rr_ptr;
    logic [2*N_SRC-1:0] rr_dbl;
    logic [N_SRC-1:0]   rr_rot;
    logic [ID_W-1:0]    rr_off;
    logic [ID_W:0]      rr_sum;
    logic [ID_W:0]      rr_nxt;
    logic [ID_W-1:0]    rr_ptr_next;

    // Rotate pending so the search start sits at bit 0. Then take the lowest
    // set bit, and map that offset back to an absolute source index.
    always_comb begin
        rr_dbl = {pending, pending} >> rr_ptr;
        rr_rot = rr_dbl[N_SRC-1:0];
        rr_off = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rr_rot[i]) begin
                rr_off = ID_W'(i);
            end
        end
        rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
        if (rr_sum >= (ID_W + 1)'(N_SRC)) begin
            rr_sum = rr_sum - (ID_W + 1)'(N_SRC);
        end
        sel_id = rr_sum[ID_W-1:0];
    end

    // Pointer value loaded when a grant is made: one past the winner, wrapped.
    always_comb begin
        rr_nxt = {1'b0, sel_id} + 1'b1;
        if (rr_nxt >= (ID_W + 1)'(N_SRC)) begin
            rr_nxt = '0;
        end
        rr_ptr_next = rr_nxt[ID_W-1:0];
    end
`else
    // Fixed priority: scan from the top down so the lowest pending index wins.
    always_comb begin
        sel_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end
`endif

    // Decode the latched request ID into the one-hot pattern for the ack pulse.
    always_comb begin
        ack_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_onehot[i] = (ID_W'(i) == irq_id_q);
        end
    end

    // Mask register. It is writable in any state, resets to all enabled, and
    // never retracts a request that has already been latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '1;
        end else if (bus.mask_we) begin
            mask_q <= bus.mask_wdata;
        end
    end

    // Request/acknowledge FSM with registered irq, irq_id and src_ack. Reset
    // aborts any request without issuing an ack pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
            src_ack_q <= '0;
`ifdef TIMER_IRQ_RR_EN
            rr_ptr    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    src_ack_q <= '0;
                    if (pending != '0) begin
                        irq_q    <= 1'b1;
                        irq_id_q <= sel_id;
                        state    <= S_ASSERT;
`ifdef TIMER_IRQ_RR_EN
                        rr_ptr   <= rr_ptr_next;
`endif
                    end
                end
                S_ASSERT: begin
                    // The latched request completes even if its source drops
                    // or gets masked. The ack pulse is harmless to the timer.
                    if (bus.cpu_ack) begin
                        irq_q     <= 1'b0;
                        src_ack_q <= ack_onehot;
                        state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    // The timer clears done on this edge. Pending is looked at
                    // again one cycle later.
                    src_ack_q <= '0;
                    state     <= S_IDLE;
                end
                default: begin
                    irq_q     <= 1'b0;
                    src_ack_q <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mask    = mask_q;
    assign bus.irq     = irq_q;
    assign bus.irq_id  = irq_id_q;
    assign bus.src_ack = src_ack_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl -- directed bench for timer_irq_ctrl with N_SRC = 4 and
// ID_W = 2. The timer side is played by the scenario tasks. Each task clears
// a done bit on the edge after its src_ack pulse, or keeps the bit set to
// mimic a re-overflow.
module tb_timer_irq_ctrl;

    localparam int N_SRC = 4;
    localparam int ID_W  = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    int n_tests;
    int n_fail;

    timer_irq_ctrl_if #(.N_SRC(N_SRC), .ID_W(ID_W)) bus ();

    timer_irq_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [N_SRC-1:0] val);
        bus.mask_wdata = val;
        bus.mask_we    = 1'b1;
        tick();
        bus.mask_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.src_done   = 4'b1111;
        bus.cpu_ack    = 1'b0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = 4'b0000;
        tick();
        tick();
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %0b want 0", bus.irq);
        end
        n_tests++;
        if (bus.src_ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_src_ack: got %b want 0000", bus.src_ack);
        end
        n_tests++;
        if (bus.mask !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_mask: got %b want 1111", bus.mask);
        end
        n_tests++;
        if (bus.irq_id !== 2'd0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_id_state: got id %0d state %0d want 0 0", bus.irq_id, state_dbg);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release_req: got irq %0b id %0d want 1 0", bus.irq, bus.irq_id);
        end
        // Serve source 0, then drop all sources to leave a clean state.
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        n_tests++;
        if (bus.src_ack !== 4'b0001 || bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_ack: got ack %b irq %0b want 0001 0", bus.src_ack, bus.irq);
        end
        tick();
        bus.src_done = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_single();
        bus.src_done = 4'b0100;
        tick();
        n_tests++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd2 || state_dbg !== 2'd1) begin
            n_fail++;
            $display("FAIL single_req: got irq %0b id %0d state %0d want 1 2 1", bus.irq, bus.irq_id, state_dbg);
        end
        tick();
        n_tests++;
        if (bus.irq !== 1'b1 || bus.src_ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_hold: got irq %0b ack %b want 1 0000", bus.irq, bus.src_ack);
        end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        n_tests++;
        if (bus.src_ack !== 4'b0100 || bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: got ack %b irq %0b want 0100 0", bus.src_ack, bus.irq);
        end
        tick();
        bus.src_done = 4'b0000;
        n_tests++;
        if (bus.src_ack !== 4'b0000 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL single_pulse_len: got ack %b state %0d want 0000 0", bus.src_ack, state_dbg);
        end
        tick();
        tick();
        n_tests++;
        if (bus.irq !== 1'b0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL single_idle: got irq %0b state %0d want 0 0", bus.irq, state_dbg);
        end
    endtask

    task automatic test_priority();
        bus.src_done = 4'b1010;
        tick();
        n_tests++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd1) begin
            n_fail++;
            $display("FAIL prio_first: got irq %0b id %0d want 1 1", bus.irq, bus.irq_id);
        end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        n_tests++;
        if (bus.src_ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL prio_ack1: got %b want 0010", bus.src_ack);
        end
        tick();
        bus.src_done = 4'b1000;
        tick();
        n_tests++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd3) begin
            n_fail++;
            $display("FAIL prio_second: got irq %0b id %0d want 1 3", bus.irq, bus.irq_id);
        end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        n_tests++;
        if (bus.src_ack !== 4'b1000) begin
            n_fail++;
            $display("FAIL prio_ack3: got %b want 1000", bus.src_ack);
        end
        tick();
        bus.src_done = 4'b0000;
        tick();
    endtask

    // Source 1 overflows again in its ack cycle, so its done bit never drops.
    // Fixed priority grants 1 again. Round-robin moves on to 3.
    task automatic test_back_to_back();
        logic [ID_W-1:0] exp_id;
`ifdef TIMER_IRQ_RR_EN
        exp_id = 2'd3;
`else
        exp_id = 2'd1;
`endif
        bus.src_done = 4'b1010;
        tick();
        n_tests++;
        if (bus.irq_id !== 2'd1 && bus.irq_id !== 2'd3) begin
            n_fail++;
            $display("FAIL b2b_first: got id %0d want 1 or 3", bus.irq_id);
        end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        tick();
        n_tests++;
        if (bus.irq !== 1'b0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_gap: got irq %0b state %0d want 0 0", bus.irq, state_dbg);
        end
        tick();
        n_tests++;
        if (bus.irq !== 1'b1 || bus.irq_id !== exp_id) begin
            n_fail++;
            $display("FAIL b2b_rerequest: got irq %0b id %0d want 1 %0d", bus.irq, bus.irq_id, exp_id);
        end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        tick();
        bus.src_done = 4'b0000;
        tick();
    endtask

    task automatic test_mask();
        logic saw_irq;
        write_mask(4'b1110);
        n_tests++;
        if (bus.mask !== 4'b1110) begin
            n_fail++;
            $display("FAIL mask_write: got %b want 1110", bus.mask);
        end
        bus.src_done = 4'b0001;
        saw_irq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.irq !== 1'b0) saw_irq = 1'b1;
        end
        n_tests++;
        if (saw_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_blocks: got irq seen %0b want 0", saw_irq);
        end
        write_mask(4'b1111);
        n_tests++;
        if (bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_first_edge: got irq %0b want 0", bus.irq);
        end
        tick();
        n_tests++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd0) begin
            n_fail++;
            $display("FAIL mask_second_edge: got irq %0b id %0d want 1 0", bus.irq, bus.irq_id);
        end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        tick();
        bus.src_done = 4'b0000;
        tick();
    endtask

    task automatic test_mask_in_assert();
        bus.src_done = 4'b0010;
        tick();
        write_mask(4'b0000);
        n_tests++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd1 || bus.mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL mask_assert_hold: got irq %0b id %0d mask %b want 1 1 0000", bus.irq, bus.irq_id, bus.mask);
        end
        tick();
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        n_tests++;
        if (bus.src_ack !== 4'b0010 || bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_assert_ack: got ack %b irq %0b want 0010 0", bus.src_ack, bus.irq);
        end
        tick();
        bus.src_done = 4'b0000;
        write_mask(4'b1111);
        tick();
    endtask

    task automatic test_ack_ignored();
        bus.src_done = 4'b0000;
        bus.cpu_ack  = 1'b1;
        tick();
        tick();
        bus.cpu_ack  = 1'b0;
        n_tests++;
        if (bus.src_ack !== 4'b0000 || bus.irq !== 1'b0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL ack_in_idle: got ack %b irq %0b state %0d want 0000 0 0", bus.src_ack, bus.irq, state_dbg);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_ack;
        bus.src_done = 4'b0100;
        tick();
        n_tests++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd2) begin
            n_fail++;
            $display("FAIL rstmid_req: got irq %0b id %0d want 1 2", bus.irq, bus.irq_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.irq !== 1'b0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got irq %0b state %0d want 0 0", bus.irq, state_dbg);
        end
        saw_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.src_ack !== 4'b0000) saw_ack = 1'b1;
        end
        rst_n = 1'b1;
        tick();
        if (bus.src_ack !== 4'b0000) saw_ack = 1'b1;
        n_tests++;
        if (saw_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_ack: got ack seen %0b want 0", saw_ack);
        end
        n_tests++;
        if (bus.irq !== 1'b1 || bus.irq_id !== 2'd2) begin
            n_fail++;
            $display("FAIL rstmid_rerequest: got irq %0b id %0d want 1 2", bus.irq, bus.irq_id);
        end
        bus.cpu_ack = 1'b1;
        tick();
        bus.cpu_ack = 1'b0;
        n_tests++;
        if (bus.src_ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstmid_ack: got %b want 0100", bus.src_ack);
        end
        tick();
        bus.src_done = 4'b0000;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_mask();
        test_mask_in_assert();
        test_ack_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Interrupt controller that sits directly downstream of the `timer` instances. It collects the sticky `done` levels from up to `N_SRC` timers and presents one masked, prioritised interrupt request with a source ID to the CPU. When the CPU acknowledges, it returns a one-cycle `done_ack` pulse to the serviced timer, closing that timer's overflow handshake.

## Interface
Parameters:
- `N_SRC`, default 4: number of timer sources, 2..16.
- `ID_W`, default 2: width of `irq_id`. Must satisfy 2**ID_W >= N_SRC.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `src_done`, in, N_SRC: `done` level from timer i on bit i.
- `src_ack`, out, N_SRC: drives `done_ack` of timer i on bit i; one-hot, one-cycle pulse.
- `mask_we`, in, 1: write strobe for the mask register.
- `mask_wdata`, in, N_SRC: new mask value; bit = 1 enables the source.
- `mask`, out, N_SRC: current mask register.
- `irq`, out, 1: interrupt request to the CPU (registered).
- `irq_id`, out, ID_W: index of the source being requested; valid while `irq` = 1.
- `cpu_ack`, in, 1: CPU acknowledge; sampled only in ASSERT.

## Operation
- `pending = src_done & mask`, evaluated combinationally each cycle.
- FSM has three states: IDLE, ASSERT, ACK.
- **IDLE**
  - If `pending` != 0: select a source, latch its index into `irq_id`, set `irq` = 1, go to ASSERT.
  - Otherwise stay in IDLE.
- **ASSERT**
  - Hold `irq` and `irq_id`.
  - On `cpu_ack` = 1: clear `irq`, set `src_ack[irq_id]` = 1, go to ACK.
- **ACK**
  - Clear `src_ack` to all-zero.
  - Go to IDLE.
- Selection: fixed priority, lowest index wins, unless round-robin is compiled in (see Configuration).
- **Mask updates**
  - `mask_we` writes `mask` on any cycle, in any state.
  - A mask change in ASSERT does not retract `irq`; the latched request completes normally.
- **Source drop in ASSERT**: if the selected source drops (e.g. the timer is re-`set`), the request is still completed. The `src_ack` pulse is harmless.
- `cpu_ack` in IDLE or ACK is ignored.

## Timing
- Reset values:
  - `irq` = 0, `irq_id` = 0, `src_ack` = 0.
  - `mask` = all ones.
  - FSM in IDLE; round-robin pointer = 0.
- Reset mid-operation aborts any request immediately. No `src_ack` pulse is issued. A source still pending after reset is re-requested.
- **Latency**
  - `src_done` high before edge k (in IDLE, enabled) → `irq` = 1 after edge k.
  - `cpu_ack` sampled high at edge m → `irq` = 0 and `src_ack` pulse high during cycle m..m+1.
  - The timer clears its `done` at edge m+1.
  - The FSM is back in IDLE after edge m+1 and re-evaluates `pending` at edge m+2.
- Minimum service cycle is 3 clocks per interrupt.
- Back-to-back requests:
  - The next pending source is requested 1 cycle after ACK.
  - The same source is re-requested if it overflowed again in the same cycle as the ack, because the timer's set-on-overflow wins over the ack-clear.
- `src_ack` is never high for more than one cycle and never has more than one bit set.
- `mask_we` takes effect on `pending` the cycle after the write edge.

## Configuration
- Macro `TIMER_IRQ_RR_EN`.
- **Defined**
  - Round-robin arbitration: the search starts at `(last_granted + 1) mod N_SRC` and wraps around.
  - The pointer updates on entry to ASSERT.
- **Undefined**
  - Fixed lowest-index priority.
  - No pointer register is synthesised.

## Test plan
- **Reset**: hold `rst_n` = 0 with `src_done` = 4'b1111 → `irq` = 0, `src_ack` = 0, `mask` = 4'b1111. Release → `irq` = 1, `irq_id` = 0 one clock later.
- **Single source handshake**: `src_done` = 4'b0100 → `irq` = 1, `irq_id` = 2. `cpu_ack` for 1 cycle → `src_ack` = 4'b0100 for exactly 1 cycle, `irq` = 0. Model timer drops `done` → FSM idles.
- **Priority** with `src_done` = 4'b1010 held by model timers:
  - Fixed: ids served in order 1, 3.
  - `TIMER_IRQ_RR_EN`: after serving 1, a re-asserted source 1 loses to 3.
- **Masking**: `mask` = 4'b1110, `src_done` = 4'b0001 → `irq` stays 0 for 10 cycles. Write `mask` = 4'b1111 → `irq` = 1, `irq_id` = 0 on the second edge after the write.
- **Mask change in ASSERT**: in ASSERT with `irq_id` = 1, write `mask` = 0 → `irq` stays 1. `cpu_ack` → `src_ack` = 4'b0010.
- **Reset mid-request**: assert `rst_n` = 0 in ASSERT → `irq` = 0 asynchronously and no `src_ack` pulse. After release, the pending source is re-requested within 1 cycle.
